// File: rtl/udp_oe_pkg.sv
// Shared Ethernet/ARP constants and state typedef for the UDP offload engine.
package udp_oe_pkg;

    localparam logic [15:0] ETHERTYPE_ARP    = 16'h0806;
    localparam logic [15:0] ARP_HTYPE        = 16'h0001;
    localparam logic [15:0] ARP_FTYPE        = 16'h0800;
    localparam logic [7:0]  ARP_HLEN         = 8'd6;
    localparam logic [7:0]  ARP_PLEN         = 8'd4;
    localparam logic [15:0] ARP_OPER         = 16'h0002;
    localparam logic [15:0] ARP_OPER_REQUEST = 16'h0001;

    localparam int ETH_HDR_BYTES     = 14;
    localparam int ARP_MIN_BYTES     = 42;
    localparam int ARP_CAPTURE_BYTES = 48;
    localparam int ARP_REPLY_BEATS   = 8;

    typedef enum logic [1:0] {
        ARP_RX_HDR   = 2'd0,
        ARP_RX_DRAIN = 2'd1,
        ARP_CHECK    = 2'd2,
        ARP_REPLY    = 2'd3
    } arp_state_t;

    // Big-endian 16-bit field laid out with its first wire byte in the low lane.
    function automatic logic [15:0] be16(input logic [15:0] v);
        return {v[7:0], v[15:8]};
    endfunction

endpackage

// File: rtl/udp_oe_arp_responder.sv
// ARP responder: captures the header of each ingress frame, answers ARP
// requests aimed at the FPGA IP with a 60-byte reply, and counts outcomes.
module udp_oe_arp_responder
    import udp_oe_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_tvalid,
    output logic        rx_tready,
    input  logic        rx_tlast,
    input  logic [63:0] rx_tdata,
    input  logic [7:0]  rx_tkeep,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    output logic        tx_tlast,
    output logic [63:0] tx_tdata,
    output logic [7:0]  tx_tkeep,
    input  logic [47:0] csr_fpga_mac,
    input  logic [31:0] csr_fpga_ip,
    output logic [31:0] arp_reply_cnt,
    output logic [31:0] arp_drop_cnt
);

    localparam logic [2:0] LAST_HDR_BEAT = 3'd5;
    localparam logic [2:0] LAST_TX_BEAT  = 3'(ARP_REPLY_BEATS - 1);
    localparam logic [5:0] RX_BYTE_SAT   = 6'(ARP_CAPTURE_BYTES);

    arp_state_t  r_state;
    // Only header bytes 12..41 are ever inspected or echoed back.
    logic [7:0]  r_hdr [12:41];
    logic [2:0]  r_rx_beat;
    logic [5:0]  r_byte_cnt;
    logic [47:0] r_mac;
    logic [31:0] r_ip;
    logic [2:0]  r_tx_beat;
    logic        r_tx_tvalid;
    logic        r_tx_tlast;
    logic [63:0] r_tx_tdata;
    logic [7:0]  r_tx_tkeep;
    logic [31:0] r_reply_cnt;
    logic [31:0] r_drop_cnt;

    logic         w_rx_ready;
    logic         w_rx_fire;
    logic [3:0]   w_keep_cnt;
    logic [6:0]   w_byte_sum;
    logic [5:0]   w_byte_cnt_next;
    logic         w_is_arp;
    logic         w_match;
    logic [47:0]  w_req_sha;
    logic [31:0]  w_req_spa;
    logic [31:0]  w_req_tpa;
    logic [47:0]  w_src_mac;
    logic [31:0]  w_src_ip;
    logic [2:0]   w_tx_idx;
    logic [511:0] w_frame;
    logic [63:0]  w_beat_data;

    assign w_rx_ready = !reset && (r_state == ARP_RX_HDR || r_state == ARP_RX_DRAIN);
    assign w_rx_fire  = rx_tvalid && w_rx_ready;

    // tkeep is contiguous from lane 0, so its popcount is the beat's byte count.
    assign w_keep_cnt      = 4'($countones(rx_tkeep));
    assign w_byte_sum      = {1'b0, r_byte_cnt} + {3'b000, w_keep_cnt};
    assign w_byte_cnt_next = (w_byte_sum >= {1'b0, RX_BYTE_SAT}) ? RX_BYTE_SAT : w_byte_sum[5:0];

    assign w_req_sha = {r_hdr[22], r_hdr[23], r_hdr[24], r_hdr[25], r_hdr[26], r_hdr[27]};
    assign w_req_spa = {r_hdr[28], r_hdr[29], r_hdr[30], r_hdr[31]};
    assign w_req_tpa = {r_hdr[38], r_hdr[39], r_hdr[40], r_hdr[41]};

    // A frame shorter than an Ethernet header carries no usable ethertype.
    assign w_is_arp = (r_byte_cnt >= 6'(ETH_HDR_BYTES)) &&
                      ({r_hdr[12], r_hdr[13]} == ETHERTYPE_ARP);
    assign w_match  = w_is_arp && (r_byte_cnt >= 6'(ARP_MIN_BYTES)) &&
                      ({r_hdr[14], r_hdr[15]} == ARP_HTYPE) &&
                      ({r_hdr[16], r_hdr[17]} == ARP_FTYPE) &&
                      (r_hdr[18] == ARP_HLEN) && (r_hdr[19] == ARP_PLEN) &&
                      ({r_hdr[20], r_hdr[21]} == ARP_OPER_REQUEST) &&
                      (w_req_tpa == csr_fpga_ip);

    // Beat 0 is loaded in CHECK while the CSRs are being sampled, so it takes
    // them directly; later beats use the held copies.
    assign w_src_mac   = (r_state == ARP_CHECK) ? csr_fpga_mac : r_mac;
    assign w_src_ip    = (r_state == ARP_CHECK) ? csr_fpga_ip  : r_ip;
    assign w_tx_idx    = (r_state == ARP_CHECK) ? 3'd0 : r_tx_beat + 3'd1;
    assign w_beat_data = w_frame[64*w_tx_idx +: 64];

    // Assemble the whole reply frame, byte n on bits [8n+7:8n], zero padded.
    always_comb begin
        w_frame = '0;
        for (int k = 0; k < 6; k++) begin
            w_frame[8*k      +: 8] = w_req_sha[47-8*k -: 8];
            w_frame[8*(6+k)  +: 8] = w_src_mac[47-8*k -: 8];
            w_frame[8*(22+k) +: 8] = w_src_mac[47-8*k -: 8];
            w_frame[8*(32+k) +: 8] = w_req_sha[47-8*k -: 8];
        end
        w_frame[8*12 +: 16] = be16(ETHERTYPE_ARP);
        w_frame[8*14 +: 16] = be16(ARP_HTYPE);
        w_frame[8*16 +: 16] = be16(ARP_FTYPE);
        w_frame[8*18 +: 8]  = ARP_HLEN;
        w_frame[8*19 +: 8]  = ARP_PLEN;
        w_frame[8*20 +: 16] = be16(ARP_OPER);
        for (int k = 0; k < 4; k++) begin
            w_frame[8*(28+k) +: 8] = w_src_ip[31-8*k -: 8];
            w_frame[8*(38+k) +: 8] = w_req_spa[31-8*k -: 8];
        end
    end

    // Receive / check / reply state machine with registered TX outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ARP_RX_HDR;
            r_rx_beat   <= '0;
            r_byte_cnt  <= '0;
            r_mac       <= '0;
            r_ip        <= '0;
            r_tx_beat   <= '0;
            r_tx_tvalid <= 1'b0;
            r_tx_tlast  <= 1'b0;
            r_tx_tdata  <= '0;
            r_tx_tkeep  <= '0;
            r_reply_cnt <= '0;
            r_drop_cnt  <= '0;
            for (int i = 12; i <= 41; i++) r_hdr[i] <= '0;
        end else begin
            case (r_state)
                ARP_RX_HDR: if (w_rx_fire) begin
                    for (int j = 0; j < 8; j++) begin
                        if (({r_rx_beat, 3'b000} + 6'(j)) >= 6'd12 &&
                            ({r_rx_beat, 3'b000} + 6'(j)) <= 6'd41)
                            r_hdr[{r_rx_beat, 3'b000} + 6'(j)] <= rx_tdata[8*j +: 8];
                    end
                    r_byte_cnt <= w_byte_cnt_next;
                    r_rx_beat  <= r_rx_beat + 3'd1;
                    if (rx_tlast)
                        r_state <= ARP_CHECK;
                    else if (r_rx_beat == LAST_HDR_BEAT)
                        r_state <= ARP_RX_DRAIN;
                end
                ARP_RX_DRAIN: if (w_rx_fire) begin
                    r_byte_cnt <= w_byte_cnt_next;
                    if (rx_tlast) r_state <= ARP_CHECK;
                end
                ARP_CHECK: begin
                    r_mac      <= csr_fpga_mac;
                    r_ip       <= csr_fpga_ip;
                    r_rx_beat  <= '0;
                    r_byte_cnt <= '0;
                    if (w_match) begin
                        r_state     <= ARP_REPLY;
                        r_tx_beat   <= '0;
                        r_tx_tvalid <= 1'b1;
                        r_tx_tdata  <= w_beat_data;
                        r_tx_tkeep  <= 8'hFF;
                        r_tx_tlast  <= 1'b0;
                    end else begin
                        r_state <= ARP_RX_HDR;
                        if (w_is_arp) r_drop_cnt <= r_drop_cnt + 32'd1;
                    end
                end
                ARP_REPLY: if (tx_tready) begin
                    if (r_tx_beat == LAST_TX_BEAT) begin
                        r_state     <= ARP_RX_HDR;
                        r_tx_tvalid <= 1'b0;
                        r_tx_tlast  <= 1'b0;
                        r_tx_tkeep  <= '0;
                        r_tx_tdata  <= '0;
                        r_reply_cnt <= r_reply_cnt + 32'd1;
                    end else begin
                        r_tx_beat  <= r_tx_beat + 3'd1;
                        r_tx_tdata <= w_beat_data;
                        r_tx_tkeep <= (w_tx_idx == LAST_TX_BEAT) ? 8'h0F : 8'hFF;
                        r_tx_tlast <= (w_tx_idx == LAST_TX_BEAT);
                    end
                end
                default: r_state <= ARP_RX_HDR;
            endcase
        end
    end

    assign rx_tready     = w_rx_ready;
    assign tx_tvalid     = r_tx_tvalid;
    assign tx_tlast      = r_tx_tlast;
    assign tx_tdata      = r_tx_tdata;
    assign tx_tkeep      = r_tx_tkeep;
    assign arp_reply_cnt = r_reply_cnt;
    assign arp_drop_cnt  = r_drop_cnt;

endmodule
